// File: rtl/marquee_pkg.sv
// marquee_arb shared types, widths and op-sequencing helpers.
// Optional op masking is enabled by defining MARQUEE_OPMASK_EN.
package marquee_pkg;

  localparam int DATA_W = 3;
  localparam int OUT_W  = 6;

  typedef enum logic [1:0] {
    OP_OR  = 2'd0,
    OP_AND = 2'd1,
    OP_XOR = 2'd2,
    OP_CAT = 2'd3
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // An all-zero mask would run no beats; treat it as all ops enabled.
  function automatic logic [3:0] fix_mask(input logic [3:0] m);
    return (m == 4'b0000) ? 4'b1111 : m;
  endfunction

  // Lowest enabled op: the first beat of a pair.
  function automatic op_e first_op(input logic [3:0] m);
    op_e r;
    r = OP_OR;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) r = op_e'(k[1:0]);
    end
    return r;
  endfunction

  // Highest enabled op: the beat carrying out_last.
  function automatic op_e last_op(input logic [3:0] m);
    op_e r;
    r = OP_OR;
    for (int k = 0; k < 4; k++) begin
      if (m[k]) r = op_e'(k[1:0]);
    end
    return r;
  endfunction

  // Next enabled op above cur; cur itself if none remain.
  function automatic op_e next_op(input logic [3:0] m,
                                  input op_e cur);
    op_e r;
    r = cur;
    for (int k = 3; k >= 0; k--) begin
      if (m[k] && (k > int'(cur))) r = op_e'(k[1:0]);
    end
    return r;
  endfunction

endpackage

// File: rtl/marquee_alu.sv
// marquee_alu: combinational op unit producing one result beat.
// Narrow results are zero-extended; CAT packs {a,b}.
module marquee_alu
  import marquee_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  op_e               op,
  output logic [OUT_W-1:0]  y
);

  localparam int PAD = OUT_W - DATA_W;

  // Select the result for the current op.
  always_comb begin
    y = '0;
    unique case (op)
      OP_OR:  y = {{PAD{1'b0}}, a | b};
      OP_AND: y = {{PAD{1'b0}}, a & b};
      OP_XOR: y = {{PAD{1'b0}}, a ^ b};
      OP_CAT: y = {a, b};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/marquee_arb.sv
// marquee_arb: two-requester arbiter streaming OR/AND/XOR/CAT beats.
// Define MARQUEE_OPMASK_EN to add the op_mask input.
module marquee_arb
  import marquee_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req1_ready,
`ifdef MARQUEE_OPMASK_EN
  input  logic [3:0]        op_mask,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [1:0]        out_op,
  output logic              out_id,
  output logic              out_last,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              id_q, id_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;

  logic [3:0] en_mask;
  logic [3:0] acc_mask;

`ifdef MARQUEE_OPMASK_EN
  logic [3:0] mask_q, mask_d;
  assign en_mask  = mask_q;
  assign acc_mask = fix_mask(op_mask);
`else
  assign en_mask  = 4'b1111;
  assign acc_mask = 4'b1111;
`endif

  logic run;
  logic any_v;
  logic gnt_id;
  logic accept;
  logic is_last;
  logic beat_done;
  logic [OUT_W-1:0] alu_y;

  assign run       = (state_q == RUN);
  assign any_v     = req0_valid | req1_valid;
  assign gnt_id    = (req0_valid & req1_valid) ? ptr_q
                                               : req1_valid;
  assign accept    = !run && any_v;
  assign is_last   = (op_q == last_op(en_mask));
  assign beat_done = run && out_ready;

  assign req0_ready = rst_n && accept && !gnt_id;
  assign req1_ready = rst_n && accept &&  gnt_id;

  marquee_alu u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (alu_y)
  );

  assign out_valid = run;
  assign busy      = run;
  assign out_data  = run ? alu_y : '0;
  assign out_op    = run ? op_q : 2'b00;
  assign out_id    = run && id_q;
  assign out_last  = run && is_last;

  // Next-state: accept a pair in IDLE, step ops on beat handshakes.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
`ifdef MARQUEE_OPMASK_EN
    mask_d  = mask_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          id_d    = gnt_id;
          a_d     = gnt_id ? req1_a : req0_a;
          b_d     = gnt_id ? req1_b : req0_b;
          op_d    = first_op(acc_mask);
`ifdef MARQUEE_OPMASK_EN
          mask_d  = acc_mask;
`endif
        end
      end
      RUN: begin
        if (beat_done) begin
          if (is_last) begin
            state_d = IDLE;
            ptr_d   = ~id_q;
            op_d    = OP_OR;
          end else begin
            op_d    = next_op(en_mask, op_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any pair in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      op_q    <= OP_OR;
      a_q     <= '0;
      b_q     <= '0;
`ifdef MARQUEE_OPMASK_EN
      mask_q  <= 4'b1111;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
`ifdef MARQUEE_OPMASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

endmodule

// File: tb/tb_marquee_arb.sv
// tb_marquee_arb: directed and random checks against a beat-queue model.
// Covers the MARQUEE_OPMASK_EN build when that macro is defined.
module tb_marquee_arb;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       out_valid, out_ready;
  logic [5:0] out_data;
  logic [1:0] out_op;
  logic       out_id, out_last, busy;
`ifdef MARQUEE_OPMASK_EN
  logic [3:0] op_mask;
`endif

  marquee_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
`ifdef MARQUEE_OPMASK_EN
    .op_mask    (op_mask),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_op     (out_op),
    .out_id     (out_id),
    .out_last   (out_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] d;
    logic [1:0] op;
    logic       id;
    logic       last;
  } beat_t;

  beat_t q[$];
  logic  mptr;
  logic  owners[$];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Build the beat list for one accepted pair from the op rules.
  task automatic push_pair(input logic id,
                           input logic [2:0] a,
                           input logic [2:0] b,
                           input logic [3:0] m);
    beat_t bt;
    logic [3:0] mm;
    mm = (m == 4'b0000) ? 4'b1111 : m;
    owners.push_back(id);
    for (int k = 0; k < 4; k++) begin
      if (mm[k]) begin
        case (k)
          0: bt.d = {3'b000, a | b};
          1: bt.d = {3'b000, a & b};
          2: bt.d = {3'b000, a ^ b};
          default: bt.d = {a, b};
        endcase
        bt.op   = 2'(k);
        bt.id   = id;
        bt.last = 1'b0;
        q.push_back(bt);
      end
    end
    bt = q[q.size()-1];
    bt.last = 1'b1;
    q[q.size()-1] = bt;
  endtask

  // Check one cycle against the model, then advance both by one edge.
  task automatic step();
    logic e0, e1, ev, el, ei;
    logic [5:0] ed;
    logic [1:0] eo;
    logic gid;
    logic [3:0] m;
    #1;
    if (q.size() == 0) begin
      e0 = req0_valid && (!req1_valid || !mptr);
      e1 = req1_valid && (!req0_valid ||  mptr);
      ev = 0; ed = 0; eo = 0; ei = 0; el = 0;
    end else begin
      e0 = 0; e1 = 0; ev = 1;
      ed = q[0].d; eo = q[0].op;
      ei = q[0].id; el = q[0].last;
    end
    chk("req0_ready", 8'(req0_ready), 8'(e0));
    chk("req1_ready", 8'(req1_ready), 8'(e1));
    chk("out_valid",  8'(out_valid),  8'(ev));
    chk("busy",       8'(busy),       8'(ev));
    chk("out_data",   8'(out_data),   8'(ed));
    chk("out_op",     8'(out_op),     8'(eo));
    chk("out_id",     8'(out_id),     8'(ei));
    chk("out_last",   8'(out_last),   8'(el));
    @(posedge clk);
    if (q.size() == 0) begin
      if (req0_valid || req1_valid) begin
        gid = (req0_valid && req1_valid) ? mptr : req1_valid;
`ifdef MARQUEE_OPMASK_EN
        m = op_mask;
`else
        m = 4'b1111;
`endif
        if (gid) push_pair(1'b1, req1_a, req1_b, m);
        else     push_pair(1'b0, req0_a, req0_b, m);
      end
    end else if (out_ready) begin
      gid = q[0].id;
      void'(q.pop_front());
      if (q.size() == 0) mptr = ~gid;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    mptr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [5:0] hold_d;
  logic [1:0] hold_o;

  initial begin
    rst_n = 1'b0;
    req0_valid = 1; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    out_ready = 1;
`ifdef MARQUEE_OPMASK_EN
    op_mask = 4'b0000;
`endif
    q.delete();
    mptr = 0;
    #3;
    chk("rst_valid", 8'(out_valid), 8'h00);
    chk("rst_busy",  8'(busy),      8'h00);
    chk("rst_data",  8'(out_data),  8'h00);
    chk("rst_ready", 8'(req0_ready), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 0;

    // Single request with operand change after acceptance.
    req0_valid = 1; req0_a = 3'b101; req0_b = 3'b011;
    step();
    req0_valid = 0; req0_a = 3'b000;
    chk("single_b0", 8'(out_data), 8'h07);
    step();
    chk("single_b1", 8'(out_data), 8'h01);
    step();
    chk("single_b2", 8'(out_data), 8'h06);
    chk("single_nl", 8'(out_last), 8'h00);
    step();
    chk("single_b3", 8'(out_data), 8'h2B);
    chk("single_l",  8'(out_last), 8'h01);
    chk("single_id", 8'(out_id),   8'h00);
    step();
    chk("single_idle", 8'(out_valid), 8'h00);

    // Backpressure on op 1.
    req0_valid = 1; req0_a = 3'b110; req0_b = 3'b011;
    step();
    req0_valid = 0;
    step();
    out_ready = 0;
    hold_d = out_data; hold_o = out_op;
    chk("bp_op1", 8'(out_op), 8'h01);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_d", 8'(out_data), 8'(hold_d));
      chk("bp_hold_o", 8'(out_op),   8'(hold_o));
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) step();

    // Contention after reset: owners alternate 0,1,0.
    do_reset();
    owners.delete();
    req0_valid = 1; req1_valid = 1;
    req0_a = 3'b001; req0_b = 3'b010;
    req1_a = 3'b111; req1_b = 3'b100;
    for (int i = 0; i < 15; i++) step();
    req0_valid = 0; req1_valid = 0;
    chk("cont_n", 8'(owners.size()), 8'd3);
    if (owners.size() == 3) begin
      chk("cont_o0", 8'(owners[0]), 8'h00);
      chk("cont_o1", 8'(owners[1]), 8'h01);
      chk("cont_o2", 8'(owners[2]), 8'h00);
    end
    step();

    // Reset mid-pair during op 2.
    req1_valid = 1; req1_a = 3'b011; req1_b = 3'b101;
    step();
    req1_valid = 0;
    step();
    step();
    chk("mid_op2", 8'(out_op), 8'h02);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_valid", 8'(out_valid), 8'h00);
    chk("mid_busy",  8'(busy),      8'h00);
    chk("mid_data",  8'(out_data),  8'h00);
    q.delete();
    mptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("mid_ptr", 8'(req0_ready), 8'h01);
    step();
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 5; i++) step();

`ifdef MARQUEE_OPMASK_EN
    op_mask = 4'b1010;
    req0_valid = 1; req0_a = 3'b101; req0_b = 3'b011;
    step();
    req0_valid = 0;
    chk("mask_b0", 8'(out_data), 8'h01);
    chk("mask_o0", 8'(out_op),   8'h01);
    chk("mask_l0", 8'(out_last), 8'h00);
    step();
    chk("mask_b1", 8'(out_data), 8'h2B);
    chk("mask_l1", 8'(out_last), 8'h01);
    step();
    chk("mask_idle", 8'(out_valid), 8'h00);
    op_mask = 4'b0000;
    req0_valid = 1;
    step();
    req0_valid = 0;
    for (int i = 0; i < 4; i++) step();
    chk("mask0_idle", 8'(out_valid), 8'h00);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 1) == 1);
      req1_valid = ($urandom_range(0, 1) == 1);
      req0_a = 3'($urandom); req0_b = 3'($urandom);
      req1_a = 3'($urandom); req1_b = 3'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef MARQUEE_OPMASK_EN
      op_mask = 4'($urandom);
`endif
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/marquee_arb.md
MARQUEE_ARB -- requirements
Module: marquee_arb

Interface
REQ-001 The block SHALL have one clock and asynchronous active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 req0_valid  input  1  requester 0 offers an operand pair.
REQ-003 req0_a, req0_b  input  3 each  requester 0 operands A, B.
REQ-004 req0_ready  output  1  requester 0 pair accepted this cycle when high with req0_valid.
REQ-005 req1_valid, req1_a, req1_b, req1_ready  same as REQ-002..004 for requester 1.
REQ-006 out_valid  output  1  out_data holds a valid result.
REQ-007 out_ready  input  1  consumer accepts the result.
REQ-008 out_data  output  6  result beat.
REQ-009 out_op  output  2  op of current beat: 0 OR, 1 AND, 2 XOR, 3 CAT.
REQ-010 out_id  output  1  owning requester of current beat.
REQ-011 out_last  output  1  final beat of current pair.
REQ-012 busy  output  1  high while a pair is in progress.

Function
REQ-013 Two states SHALL exist: IDLE and RUN.
REQ-014 In IDLE, reqN_ready SHALL be combinationally high only for the granted requester; both readys SHALL be low in RUN.
REQ-015 Grant: if only one reqN_valid is high, that requester is granted; if both are high, the requester named by the 1-bit priority pointer is granted.
REQ-016 On acceptance (reqN_valid && reqN_ready at a rising edge), the block SHALL capture A, B and the owner id, set op to 0, and enter RUN.
REQ-017 Latency: first beat SHALL appear with out_valid=1 in the cycle after acceptance.
REQ-018 In RUN, out_valid=1 and busy=1; out_data SHALL be {3'b000, A|B}, {3'b000, A&B}, {3'b000, A^B} or {A,B} for op 0..3.
REQ-019 Beat handshake: on out_valid && out_ready, op SHALL advance by one; while out_ready=0, out_data, out_op, out_id and out_last SHALL hold stable.
REQ-020 out_last SHALL be high on the last beat (op 3 without masking).
REQ-021 On a completed last-beat handshake, the block SHALL return to IDLE and set the pointer to the other requester.
REQ-022 A new pair SHALL NOT be accepted in the same cycle as the last beat, giving a minimum of 5 cycles per pair.
REQ-023 Operand inputs SHALL be ignored except at acceptance; changes during RUN SHALL have no effect.
REQ-024 In IDLE, out_valid=0, out_last=0 and out_data/out_op/out_id SHALL be 0.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, pointer=0, op=0, captured operands=0, and all outputs to 0, including mid-pair; the abandoned pair is dropped.
REQ-026 The first grant after reset with both requesters valid SHALL go to requester 0.

Configuration
REQ-027 Macro MARQUEE_OPMASK_EN, when defined, SHALL add input op_mask[3:0] (bit k enables op k), sampled at acceptance; disabled ops are skipped without a beat, and out_last marks the highest enabled op.
REQ-028 With MARQUEE_OPMASK_EN defined, op_mask=4'b0000 SHALL be treated as 4'b1111.
REQ-029 Without MARQUEE_OPMASK_EN, the op_mask port SHALL be absent and all four ops SHALL always run.

Structure
REQ-030 Package marquee_pkg SHALL hold op_e (OP_OR=0, OP_AND=1, OP_XOR=2, OP_CAT=3), state_e (IDLE, RUN), DATA_W=3 and OUT_W=6.
REQ-031 The combinational op unit SHALL be a sub-module marquee_alu with inputs a, b and op, and output y[5:0]; marquee_arb SHALL instantiate it once.

Verification
REQ-032 Single request: req0 A=3'b101, B=3'b011, out_ready=1 -> beats 6'h07, 6'h01, 6'h06, 6'h2B; out_id=0; out_last on the 4th beat.
REQ-033 Contention: both valid for 3 pairs after reset -> owners 0, 1, 0; each pair is 4 beats with 1 IDLE cycle between pairs.
REQ-034 Backpressure: out_ready=0 for 3 cycles on beat op=1 -> outputs held stable; sequence resumes at op=1 with no beat lost or duplicated.
REQ-035 Reset mid-pair: assert rst_n=0 during op=2 -> out_valid drops asynchronously; after release, IDLE with pointer=0.
REQ-036 Operand change during RUN: change req0_a to 3'b000 after acceptance -> beats still use the captured A=3'b101.
REQ-037 With MARQUEE_OPMASK_EN: op_mask=4'b1010, A=3'b101, B=3'b011 -> two beats, 6'h01 (op1) then 6'h2B (op3, out_last=1); op_mask=0 -> four beats.
